// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a 1-cycle registered instruction memory.
// It owns the PC, tracks the single in-flight read, and holds returned words in an
// output register plus a skid register so that backpressure never drops a word.
module fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 64,
   parameter int DATA_WIDTH = 32,
   parameter int RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  halt,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] mem_address,
   input  logic [DATA_WIDTH-1:0] mem_instruction,
   output logic                  dec_valid,
   input  logic                  dec_ready,
   output logic [DATA_WIDTH-1:0] dec_instruction,
   output logic [ADDR_WIDTH-1:0] dec_pc
);

   localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

   logic [ADDR_WIDTH-1:0] pc;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  inflight_valid;
   logic [ADDR_WIDTH-1:0] inflight_pc;
   logic                  skid_valid;
   logic [DATA_WIDTH-1:0] skid_instruction;
   logic [ADDR_WIDTH-1:0] skid_pc;

   logic [1:0] occ;
   logic       pop;
   logic       issue;
   logic       out_free;
   logic       out_load_arrival;
   logic       out_load_skid;
   logic       out_clear;
   logic       skid_load;
   logic       skid_clear;

   assign mem_address = pc;

   // Issue decision: a new fetch goes out only if the buffer can still absorb it
   // once the word lands (stored + in flight, minus this cycle's pop, at most 1).
   always_comb begin
      occ      = {1'b0, dec_valid} + {1'b0, skid_valid} + {1'b0, inflight_valid};
      pop      = dec_valid & dec_ready;
      out_free = ~dec_valid | pop;
      issue    = rst_n & ~halt & ~redirect_valid & ((occ - {1'b0, pop}) <= 2'd1);
      pc_next  = (pc == PC_LAST) ? '0 : pc + ADDR_WIDTH'(1);
   end

   // Buffer steering: the skid entry is always older than a fresh arrival, so it
   // moves to the output first and the arrival takes its place.
   always_comb begin
      out_load_arrival = 1'b0;
      out_load_skid    = 1'b0;
      out_clear        = 1'b0;
      skid_load        = 1'b0;
      skid_clear       = 1'b0;
      if (inflight_valid) begin
         if (out_free) begin
            if (skid_valid) begin
               out_load_skid = 1'b1;
               skid_load     = 1'b1;
            end else begin
               out_load_arrival = 1'b1;
            end
         end else begin
            skid_load = 1'b1;
         end
      end else if (out_free) begin
         if (skid_valid) begin
            out_load_skid = 1'b1;
            skid_clear    = 1'b1;
         end else begin
            out_clear = 1'b1;
         end
      end
   end

   // PC and in-flight tracking; redirect squashes the outstanding read and reloads the PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc             <= PC_RESET;
         inflight_valid <= 1'b0;
      end else if (redirect_valid) begin
         pc             <= redirect_target;
         inflight_valid <= 1'b0;
      end else begin
         inflight_valid <= issue;
         if (issue) pc <= pc_next;
      end
   end

   // Remember which PC the outstanding read belongs to.
   always_ff @(posedge clk) begin
      if (issue) inflight_pc <= pc;
   end

   // Output register toward the decoder; held stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_valid       <= 1'b0;
         dec_instruction <= '0;
         dec_pc          <= '0;
      end else if (redirect_valid) begin
         dec_valid <= 1'b0;
      end else if (out_load_skid) begin
         dec_valid       <= 1'b1;
         dec_instruction <= skid_instruction;
         dec_pc          <= skid_pc;
      end else if (out_load_arrival) begin
         dec_valid       <= 1'b1;
         dec_instruction <= mem_instruction;
         dec_pc          <= inflight_pc;
      end else if (out_clear) begin
         dec_valid <= 1'b0;
      end
   end

   // Skid occupancy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_valid <= 1'b0;
      end else if (redirect_valid) begin
         skid_valid <= 1'b0;
      end else if (skid_load) begin
         skid_valid <= 1'b1;
      end else if (skid_clear) begin
         skid_valid <= 1'b0;
      end
   end

   // Skid payload; only meaningful while skid_valid is set.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_instruction <= mem_instruction;
         skid_pc          <= inflight_pc;
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter, drives the memory word address, and absorbs the memory's fixed 1-cycle registered read latency. It presents each returned instruction with its PC to the decoder over a valid/ready handshake, and supports backpressure, halt and branch/jump redirect. Internally it uses a 2-entry output buffer (output register plus skid register) so no returned word is ever lost.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address (word index, not byte address)
MEM_DEPTH, 64, number of instruction words; PC wraps from MEM_DEPTH-1 to 0
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  single clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
halt  in  1  level; while high, no new fetches are issued
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_target
redirect_target  in  ADDR_WIDTH  new PC, word index, must be < MEM_DEPTH
mem_address  out  ADDR_WIDTH  word address to instruction memory; sampled by memory at posedge
mem_instruction  in  DATA_WIDTH  memory read data; valid 1 cycle after the address edge
dec_valid  out  1  instruction/PC on outputs are valid
dec_ready  in  1  decoder accepts this cycle
dec_instruction  out  DATA_WIDTH  fetched instruction
dec_pc  out  ADDR_WIDTH  word address the instruction came from

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC; dec_valid=0; dec_instruction=0; dec_pc=0; skid_valid=0; inflight_valid=0.
- mem_address = pc, combinational from the pc register.
- Issue: occ = dec_valid + skid_valid + inflight_valid; pop = dec_valid & dec_ready.
  - issue = rst_n & !halt & !redirect_valid & (occ - pop <= 1).
  - On issue: inflight_valid<=1, inflight_pc<=pc, pc<=pc+1 (pc<=0 if pc==MEM_DEPTH-1).
  - Otherwise: inflight_valid<=0 and pc holds.
- Arrival: when inflight_valid=1, mem_instruction is captured that edge, paired with inflight_pc.
  - If the output register is empty or popped this cycle: write it, unless skid holds an older entry.
  - Skid is older than the arrival: skid moves to output, arrival goes to skid.
- Order invariant: instructions reach the decoder strictly in PC issue order, no duplicates, no drops.
- Occupancy never exceeds 2 stored entries.
- Throughput: 1 instruction/cycle with dec_ready=1 and halt=0.
- Latency: issue edge to dec_valid = 2 posedges. After reset release, dec_valid rises at the 2nd posedge with dec_pc=RESET_PC.
- Outputs are stable while dec_valid=1 and dec_ready=0.
- Redirect (highest priority):
  - The transfer on the current cycle still completes if dec_valid & dec_ready.
  - At the edge: dec_valid<=0, skid_valid<=0, inflight_valid<=0 (squash), pc<=redirect_target, no issue.
  - Next cycle issues redirect_target; its dec_valid appears 3 edges after the redirect edge.
  - Redirect during halt: pc loads the target; fetch resumes from the target when halt drops.
- Halt: stops only issue. Already buffered or in-flight words still drain to the decoder.
- Simultaneous halt rise and arrival: the arrival is kept.
- Mid-operation reset: all valids clear immediately (async); the in-flight word is discarded; restart from RESET_PC.

Test Plan:
- Reset then dec_ready=1, mem[i]=i+0x100: dec_valid rises at 2nd edge; dec_pc 0,1,2,... each cycle with instruction 0x100,0x101,...; no gaps.
- Stream, then dec_ready=0 for 5 cycles, then 1: pc advances by at most 2 during the stall; dec_instruction/dec_pc frozen; resume yields consecutive PCs with none missing or repeated.
- Redirect pulse to 40 while PCs 3,4 are buffered/in flight: 3 and 4 never appear after the edge; the next valid output is dec_pc=40 with mem[40], 3 edges later.
- Fetch through 62,63: the next dec_pc is 0 (wrap at MEM_DEPTH=64).
- halt=1 for 4 cycles with dec_ready=1: buffered words drain; dec_valid then 0; mem_address constant; on release, PCs continue from the held pc.
- rst_n low for 1 cycle during backpressure with 2 entries stored: dec_valid drops asynchronously; after release the sequence restarts at dec_pc=0.
